// File: rtl/usart_pkg.sv
// Shared USART definitions: receiver FSM encoding, default line settings and
// the elaboration-time helpers used to size counters and pointers.
package usart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam int DEFAULT_CLK_FREQ  = 100000000;
  localparam int DEFAULT_BAUD_RATE = 115200;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

  function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/usart_fifo.sv
// Synchronous show-ahead FIFO: rd_data always presents the head entry, and a
// pop while full frees the slot for a simultaneous push.
module usart_fifo
  import usart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_wr;
  logic             do_rd;

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);
  assign do_rd = rd_en & ~empty;
  assign do_wr = wr_en & (~full | do_rd);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/usart_rx.sv
// 8N1-style UART receiver: synchronizes rx, frames characters LSB first at
// mid-bit sample points and buffers good bytes in a show-ahead FIFO.
module usart_rx
  import usart_pkg::*;
#(
  parameter int CLK_FREQ     = DEFAULT_CLK_FREQ,
  parameter int BAUD_RATE    = DEFAULT_BAUD_RATE,
  parameter int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE),
  parameter int DATA_BIT     = 8,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rx,
  input  logic                rd_en,
  output logic [DATA_BIT-1:0] rd_data,
  output logic                empty,
  output logic                full,
  output logic                frame_err,
  output logic                overrun
);

  localparam int CW = clog2(CLKS_PER_BIT) + 1;
  localparam int IW = clog2(DATA_BIT + 1);
  localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BIT - 1);

  rx_state_t           state;
  rx_state_t           state_n;
  logic                rx_p0;
  logic                rx_s;
  logic                rx_d;
  logic [CW-1:0]       cnt;
  logic [CW-1:0]       cnt_n;
  logic [IW-1:0]       bit_idx;
  logic [IW-1:0]       idx_n;
  logic [DATA_BIT-1:0] shift_reg;
  logic [DATA_BIT-1:0] shift_n;
  logic                stop_smp;
  logic                pop;
  logic                push;
  logic                fe_n;
  logic                ov_n;

  assign pop  = rd_en & ~empty;
  // A pop in the stop-sample cycle frees a slot, so a full FIFO still accepts.
  assign push = stop_smp & rx_s & (~full | pop);
  assign fe_n = stop_smp & ~rx_s;
  assign ov_n = stop_smp & rx_s & full & ~pop;

  always_comb begin
    state_n  = state;
    cnt_n    = cnt + CW'(1);
    idx_n    = bit_idx;
    shift_n  = shift_reg;
    stop_smp = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (rx_d && !rx_s) state_n = START;
      end
      START: begin
        if (cnt == HALF_M1) begin
          cnt_n = '0;
          if (!rx_s) begin
            idx_n   = '0;
            state_n = DATA;
          end else begin
            state_n = IDLE;
          end
        end
      end
      DATA: begin
        if (cnt == FULL_M1) begin
          cnt_n = '0;
          for (int i = 0; i < DATA_BIT; i++) begin
            if (bit_idx == IW'(i)) shift_n[i] = rx_s;
          end
          if (bit_idx == LAST_IDX) state_n = STOP;
          else                     idx_n   = bit_idx + IW'(1);
        end
      end
      STOP: begin
        // Leave mid-stop-bit so the next start edge is never missed.
        if (cnt == FULL_M1) begin
          cnt_n    = '0;
          stop_smp = 1'b1;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Synchronizer and framing control
  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_p0     <= 1'b1;
      rx_s      <= 1'b1;
      rx_d      <= 1'b1;
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      rx_p0     <= rx;
      rx_s      <= rx_p0;
      rx_d      <= rx_s;
      state     <= state_n;
      cnt       <= cnt_n;
      bit_idx   <= idx_n;
      frame_err <= fe_n;
      overrun   <= ov_n;
    end
  end

  always_ff @(posedge clk) begin
    shift_reg <= shift_n;
  end

  usart_fifo #(
    .WIDTH (DATA_BIT),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push),
    .wr_data (shift_reg),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .empty   (empty),
    .full    (full)
  );

endmodule

// File: tb/tb_usart_rx.sv
// Directed bench for usart_rx at 10 clocks per bit (clock period 10 units,
// nominal bit period 100 units), with hand-computed expected bytes.
module tb_usart_rx;
  import usart_pkg::*;

  logic       clk;
  logic       reset;
  logic       rx;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       empty;
  logic       full;
  logic       frame_err;
  logic       overrun;

  int n_cmp;
  int n_err;
  int fe_cnt;
  int ov_cnt;
  int fe0;
  int ov0;
  int lat;
  bit got;

  usart_rx #(
    .CLK_FREQ   (1000000),
    .BAUD_RATE  (100000),
    .DATA_BIT   (8),
    .FIFO_DEPTH (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .empty     (empty),
    .full      (full),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err) fe_cnt++;
    if (overrun)   ov_cnt++;
  end

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input int bp);
    rx = 1'b0;
    #(bp);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      #(bp);
    end
    rx = stop_b;
    #(bp);
  endtask

  task automatic pop_chk(input logic [7:0] exp, input string tag);
    chk(32'(rd_data), 32'(exp), tag);
    rd_en = 1'b1;
    @(posedge clk);
    #1;
    rd_en = 1'b0;
  endtask

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    fe_cnt = 0;
    ov_cnt = 0;
    reset  = 1'b0;
    rx     = 1'b1;
    rd_en  = 1'b0;
    cycles(3);
    chk(32'(empty), 1, "reset_empty");
    chk(32'(full), 0, "reset_full");
    chk(32'(frame_err), 0, "reset_frame_err");
    chk(32'(overrun), 0, "reset_overrun");
    chk(32'(dut.state), 32'(IDLE), "reset_state");
    reset = 1'b1;
    cycles(5);

    // 1: single byte 0xA5 with edge-to-push latency measurement
    rx = 1'b0;
    #100;
    for (int i = 0; i < 8; i++) begin
      rx = (8'hA5 >> i) & 1'b1;
      #100;
    end
    rx  = 1'b1;
    lat = 90;
    got = 1'b0;
    for (int k = 0; k < 30 && !got; k++) begin
      @(posedge clk);
      #1;
      lat++;
      if (!empty) got = 1'b1;
    end
    chk(32'(got), 1, "single_arrived");
    chk(32'(lat >= 96 && lat <= 99), 1, "single_latency");
    cycles(4);
    pop_chk(8'hA5, "single_data");
    chk(32'(empty), 1, "single_empty_after_pop");
    chk(32'(fe_cnt), 0, "single_no_frame_err");

    // 2: back-to-back bytes, no idle gap
    send_frame(8'h00, 1'b1, 100);
    send_frame(8'hFF, 1'b1, 100);
    send_frame(8'h55, 1'b1, 100);
    cycles(5);
    pop_chk(8'h00, "b2b_0");
    pop_chk(8'hFF, "b2b_1");
    pop_chk(8'h55, "b2b_2");
    chk(32'(empty), 1, "b2b_empty");
    chk(32'(fe_cnt), 0, "b2b_no_frame_err");

    // 3: glitch, framing error, held-low line
    fe0 = fe_cnt;
    rx  = 1'b0;
    #30;
    rx  = 1'b1;
    cycles(150);
    chk(32'(empty), 1, "glitch_no_byte");
    chk(32'(fe_cnt), 32'(fe0), "glitch_no_err");
    send_frame(8'h3C, 1'b0, 100);
    cycles(5);
    chk(32'(fe_cnt), 32'(fe0 + 1), "frame_err_one_cycle");
    chk(32'(empty), 1, "frame_err_fifo_unchanged");
    cycles(300);
    chk(32'(dut.state), 32'(IDLE), "break_no_start");
    chk(32'(fe_cnt), 32'(fe0 + 1), "break_no_more_err");
    rx = 1'b1;
    cycles(20);

    // 4: fill, overrun, then pop coincident with a push while full
    ov0 = ov_cnt;
    for (int b = 1; b <= 16; b++) send_frame(8'(b), 1'b1, 100);
    cycles(3);
    chk(32'(full), 1, "full_after_16");
    chk(32'(ov_cnt), 32'(ov0), "no_overrun_at_16");
    send_frame(8'h11, 1'b1, 100);
    cycles(3);
    chk(32'(ov_cnt), 32'(ov0 + 1), "overrun_on_17");
    chk(32'(rd_data), 32'h01, "head_after_overrun");
    chk(32'(full), 1, "still_full");
    rx = 1'b0;
    #100;
    for (int i = 0; i < 8; i++) begin
      rx = (8'h12 >> i) & 1'b1;
      #100;
    end
    rx = 1'b1;
    repeat (lat - 91) @(posedge clk);
    #1;
    rd_en = 1'b1;
    @(posedge clk);
    #1;
    rd_en = 1'b0;
    cycles(5);
    chk(32'(ov_cnt), 32'(ov0 + 1), "pop_push_no_overrun");
    chk(32'(full), 1, "pop_push_full");
    for (int b = 2; b <= 16; b++) pop_chk(8'(b), "drain_order");
    pop_chk(8'h12, "drain_last");
    chk(32'(empty), 1, "drain_empty");

    // 5: reset mid-frame discards partial byte and FIFO contents
    send_frame(8'h33, 1'b1, 100);
    cycles(3);
    chk(32'(empty), 0, "pre_reset_byte");
    rx = 1'b0;
    #100;
    for (int i = 0; i < 4; i++) begin
      rx = (8'h7E >> i) & 1'b1;
      #100;
    end
    rx = 1'b1;
    #50;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk(32'(empty), 1, "midreset_empty");
    chk(32'(dut.state), 32'(IDLE), "midreset_state");
    reset = 1'b1;
    cycles(20);
    chk(32'(empty), 1, "midreset_no_partial");
    send_frame(8'h81, 1'b1, 100);
    cycles(3);
    pop_chk(8'h81, "after_reset_data");
    chk(32'(empty), 1, "after_reset_empty");

    // 6: +/-3% bit period
    fe0 = fe_cnt;
    send_frame(8'h96, 1'b1, 97);
    cycles(3);
    pop_chk(8'h96, "fast_baud_data");
    send_frame(8'h96, 1'b1, 103);
    cycles(3);
    pop_chk(8'h96, "slow_baud_data");
    chk(32'(fe_cnt), 32'(fe0), "baud_no_frame_err");
    chk(32'(empty), 1, "final_empty");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
